// File: rtl/mux_bus_arbiter_if.sv
// Shared result-bus bundle: four requesters, one consumer, arbiter status.
// The slave modport is the arbiter's view; master is the requester/consumer side.
interface mux_bus_arbiter_if #(
  parameter int DATA_W = 20
);
  logic [3:0]        req;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [DATA_W-1:0] in3;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        sel;
  logic [3:0]        grant;
  logic [3:0]        ack;
  logic              timeout_err;

  modport slave (
    input  req, in0, in1, in2, in3, out_ready,
    output out_valid, out_data, sel, grant, ack, timeout_err
  );

  modport master (
    output req, in0, in1, in2, in3, out_ready,
    input  out_valid, out_data, sel, grant, ack, timeout_err
  );
endinterface

// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter sharing one result bus among four requesters, with a
// valid/ready handshake to the consumer, withdrawal abort and a wait timeout.
//
// state | meaning
// IDLE  | no grant; arbitrate among req starting at ptr_q
// BUSY  | word from in[sel] offered on out_data, waiting for out_ready
module mux_bus_arbiter #(
  parameter int DATA_W  = 20,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_bus_arbiter_if.slave     bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q,   sel_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [7:0] cnt_q,   cnt_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] scan_idx;
  logic       busy;
  logic       cnt_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // ptr_q is the first index to consider: one past the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    scan_idx  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!win_found && bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign busy        = (state_q == BUSY);
  assign cnt_expired = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BUSY;
          grant_d = 4'b0001 << win_idx;
          sel_d   = win_idx;
          cnt_d   = 8'd0;
        end
      end
      BUSY: begin
        // Completion, withdrawal and timeout all end the grant the same way.
        if (bus.out_ready || !bus.req[sel_q] || cnt_expired) begin
          state_d = IDLE;
          grant_d = 4'b0000;
          ptr_d   = sel_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  always_comb begin
    bus.out_valid   = busy;
    bus.grant       = grant_q;
    bus.sel         = sel_q;
    bus.ack         = (busy && bus.out_ready) ? grant_q : 4'b0000;
    bus.timeout_err = busy && !bus.out_ready && cnt_expired;
    case (sel_q)
      2'd0:    bus.out_data = bus.in0;
      2'd1:    bus.out_data = bus.in1;
      2'd2:    bus.out_data = bus.in2;
      default: bus.out_data = bus.in3;
    endcase
  end

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Directed bench for mux_bus_arbiter: table-driven round-robin vectors plus
// hand-written stall, timeout, withdrawal and mid-transfer reset sequences.
module tb_mux_bus_arbiter;
  localparam int DW = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_bus_arbiter_if #(.DATA_W(DW)) bus ();

  mux_bus_arbiter #(.DATA_W(DW), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [DW-1:0] din [4];
  assign bus.in0 = din[0];
  assign bus.in1 = din[1];
  assign bus.in2 = din[2];
  assign bus.in3 = din[3];

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic [3:0] ack;
  } vec_t;

  vec_t tbl [14];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic v, input logic [3:0] a, input logic to);
    #3;
    chk({tag, ".grant"},       32'(bus.grant),       32'(g));
    chk({tag, ".sel"},         32'(bus.sel),         32'(s));
    chk({tag, ".out_valid"},   32'(bus.out_valid),   32'(v));
    chk({tag, ".ack"},         32'(bus.ack),         32'(a));
    chk({tag, ".timeout_err"}, 32'(bus.timeout_err), 32'(to));
    chk({tag, ".out_data"},    32'(bus.out_data),    32'(din[s]));
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 4'b0000};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 4'b0000};
    tbl[7]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b1000};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 4'b0000};
    tbl[9]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
    tbl[11] = '{4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
    tbl[12] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 4'b0000};

    din[0] = 20'h11111;
    din[1] = 20'h22222;
    din[2] = 20'hABCDE;
    din[3] = 20'h33333;
    bus.req       = 4'b0000;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk_out("reset", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    tick();

    // Round-robin 0,1,2,3,0 with an IDLE cycle between grants, then a single req[2].
    for (int i = 0; i < 14; i++) begin
      bus.req       = tbl[i].req;
      bus.out_ready = tbl[i].rdy;
      chk_out($sformatf("vec%0d", i), tbl[i].grant, tbl[i].sel, tbl[i].valid, tbl[i].ack, 1'b0);
      tick();
    end

    // Consumer stalls five cycles before accepting requester 1.
    bus.req = 4'b0010; bus.out_ready = 1'b0;
    chk_out("stall_idle", 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0);
    tick();
    for (int k = 1; k <= 6; k++) begin
      bus.out_ready = (k == 6);
      chk_out($sformatf("stall_c%0d", k), 4'b0010, 2'd1, 1'b1,
              (k == 6) ? 4'b0010 : 4'b0000, 1'b0);
      tick();
    end
    bus.req = 4'b0000; bus.out_ready = 1'b0;
    chk_out("stall_done", 4'b0000, 2'd1, 1'b0, 4'b0000, 1'b0);
    tick();

    // Requester 3 never accepted: timeout on the 15th BUSY cycle.
    bus.req = 4'b1000;
    chk_out("to_idle0", 4'b0000, 2'd1, 1'b0, 4'b0000, 1'b0);
    tick();
    for (int k = 1; k <= 15; k++) begin
      chk_out($sformatf("to_c%0d", k), 4'b1000, 2'd3, 1'b1, 4'b0000, k == 15);
      tick();
    end
    bus.req = 4'b1001;
    chk_out("to_idle1", 4'b0000, 2'd3, 1'b0, 4'b0000, 1'b0);
    tick();
    bus.out_ready = 1'b1;
    chk_out("to_next", 4'b0001, 2'd0, 1'b1, 4'b0001, 1'b0);
    tick();
    bus.req = 4'b0000; bus.out_ready = 1'b0;
    chk_out("to_done", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    tick();

    // Requester 0 withdraws while stalled.
    bus.req = 4'b0001;
    chk_out("wd_idle0", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    tick();
    chk_out("wd_busy", 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0);
    bus.req = 4'b0000;
    chk_out("wd_drop", 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0);
    tick();
    bus.req = 4'b0011;
    chk_out("wd_idle1", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    tick();
    bus.out_ready = 1'b1;
    chk_out("wd_win1", 4'b0010, 2'd1, 1'b1, 4'b0010, 1'b0);
    tick();
    bus.req = 4'b0100; bus.out_ready = 1'b0;
    chk_out("wd_idle2", 4'b0000, 2'd1, 1'b0, 4'b0000, 1'b0);
    tick();
    // Withdrawal and ready together: ready wins.
    bus.req = 4'b0000; bus.out_ready = 1'b1;
    chk_out("wd_ready_wins", 4'b0100, 2'd2, 1'b1, 4'b0100, 1'b0);
    tick();
    chk_out("wd_idle3", 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0);

    // Reset in the middle of an accepted transfer.
    bus.req = 4'b0001;
    tick();
    chk_out("rst_busy", 4'b0001, 2'd0, 1'b1, 4'b0001, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_async.grant",       32'(bus.grant),       32'(4'b0000));
    chk("rst_async.out_valid",   32'(bus.out_valid),   32'(1'b0));
    chk("rst_async.ack",         32'(bus.ack),         32'(4'b0000));
    chk("rst_async.sel",         32'(bus.sel),         32'(2'd0));
    chk("rst_async.timeout_err", 32'(bus.timeout_err), 32'(1'b0));
    bus.req = 4'b0000; bus.out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req = 4'b1000;
    chk_out("rst_idle", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    tick();
    chk_out("rst_after", 4'b1000, 2'd3, 1'b1, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
